// File: rtl/seg7_bin_display.sv
// Sequential binary-to-7-segment driver: shift-and-add-3 BCD conversion, then blanking/sign/overflow encode.
// Optional SEG7_BLINK_EN adds a blink input and BLINK_DIV parameter that periodically blanks all digits.
module seg7_bin_display #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_DIV = 25_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic                  neg,
`ifdef SEG7_BLINK_EN
  input  logic                  blink,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_MINUS = 7'b011_1111;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ENCODE} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_val;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_neg;
  logic                  r_ovf;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf_out;
  logic [7*DIGITS-1:0]   r_seg;

  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_shifted;
  int                    w_msd;
  logic                  w_ovf_all;
  logic [7*DIGITS-1:0]   w_seg_next;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b100_0000;
      4'd1:    return 7'b111_1001;
      4'd2:    return 7'b010_0100;
      4'd3:    return 7'b011_0000;
      4'd4:    return 7'b001_1001;
      4'd5:    return 7'b001_0010;
      4'd6:    return 7'b000_0010;
      4'd7:    return 7'b111_1000;
      4'd8:    return 7'b000_0000;
      4'd9:    return 7'b001_0000;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++)
      w_adj[4*i +: 4] = add3(r_bcd[4*i +: 4]);
    w_shifted = {w_adj[4*DIGITS-2:0], r_val[WIDTH-1]};
  end

  // A negative number that fills every digit leaves no room for the minus sign.
  always_comb begin
    w_msd = 0;
    for (int i = 0; i < DIGITS; i++)
      if (r_bcd[4*i +: 4] != 4'd0) w_msd = i;
    w_ovf_all  = r_ovf | (r_neg & (w_msd == DIGITS - 1));
    w_seg_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_ovf_all)                     w_seg_next[7*i +: 7] = SEG_MINUS;
      else if (i <= w_msd)               w_seg_next[7*i +: 7] = enc_digit(r_bcd[4*i +: 4]);
      else if (r_neg && i == w_msd + 1)  w_seg_next[7*i +: 7] = SEG_MINUS;
      else                               w_seg_next[7*i +: 7] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf_out <= 1'b0;
      r_seg     <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_val   <= value;
            r_neg   <= neg;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= CNT_W'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_shifted;
          r_val <= r_val << 1;
          r_ovf <= r_ovf | w_adj[4*DIGITS-1];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= S_ENCODE;
        end
        S_ENCODE: begin
          r_seg     <= w_seg_next;
          r_ovf_out <= w_ovf_all;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf_out;

`ifdef SEG7_BLINK_EN
  localparam int DIV_W = $clog2(BLINK_DIV + 1);
  logic [DIV_W-1:0] r_bcnt;
  logic             r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (r_bcnt == DIV_W'(BLINK_DIV - 1)) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + 1'b1;
    end
  end

  assign seg = (blink && r_phase) ? '1 : r_seg;
`else
  assign seg = r_seg;
`endif

endmodule

// File: tb/tb_seg7_bin_display.sv
// Bench for seg7_bin_display: two instances (4 and 2 digits) share inputs; table vectors, corner sequences, random vs decimal model.
module tb_seg7_bin_display;

  localparam logic [6:0] S0 = 7'b100_0000, S1 = 7'b111_1001, S2 = 7'b010_0100;
  localparam logic [6:0] S5 = 7'b001_0010, S7 = 7'b111_1000, S9 = 7'b001_0000;
  localparam logic [6:0] B  = 7'b111_1111, M  = 7'b011_1111;

  logic        clk = 1'b0;
  logic        rst, load, neg;
  logic [7:0]  value;
  logic        busy4, done4, ovf4, busy2, done2, ovf2;
  logic [27:0] seg4;
  logic [13:0] seg2;
`ifdef SEG7_BLINK_EN
  logic        blink;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_bin_display #(.WIDTH(8), .DIGITS(4)
`ifdef SEG7_BLINK_EN
    , .BLINK_DIV(4)
`endif
  ) u_dut4 (
    .clk(clk), .rst(rst), .load(load), .value(value), .neg(neg),
`ifdef SEG7_BLINK_EN
    .blink(blink),
`endif
    .busy(busy4), .done(done4), .overflow(ovf4), .seg(seg4));

  seg7_bin_display #(.WIDTH(8), .DIGITS(2)
`ifdef SEG7_BLINK_EN
    , .BLINK_DIV(4)
`endif
  ) u_dut2 (
    .clk(clk), .rst(rst), .load(load), .value(value), .neg(neg),
`ifdef SEG7_BLINK_EN
    .blink(blink),
`endif
    .busy(busy2), .done(done2), .overflow(ovf2), .seg(seg2));

  typedef struct {
    logic [7:0]  v;
    logic        n;
    logic [27:0] s4;
    logic        o4;
    logic [13:0] s2;
    logic        o2;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] segof(input int d);
    case (d)
      0: return 7'b100_0000;  1: return 7'b111_1001;
      2: return 7'b010_0100;  3: return 7'b011_0000;
      4: return 7'b001_1001;  5: return 7'b001_0010;
      6: return 7'b000_0010;  7: return 7'b111_1000;
      8: return 7'b000_0000;  default: return 7'b001_0000;
    endcase
  endfunction

  // Decimal reference: count digits arithmetically, then lay out digits, sign and blanks.
  function automatic logic [27:0] model_seg(input int v, input bit n, input int d, output bit o);
    logic [27:0] s;
    int t, nd;
    t = v; nd = 1;
    while (t >= 10) begin t = t / 10; nd++; end
    o = (nd > d) || (n && nd >= d);
    s = '0; t = v;
    for (int i = 0; i < d; i++) begin
      if (o)                  s[7*i +: 7] = M;
      else if (i < nd) begin  s[7*i +: 7] = segof(t % 10); t = t / 10; end
      else if (n && i == nd)  s[7*i +: 7] = M;
      else                    s[7*i +: 7] = B;
    end
    return s;
  endfunction

  // Called just after a clock edge; returns number of edges from the load edge to done.
  task automatic convert(input logic [7:0] v, input logic n, output int lat, output logic b);
    value = v; neg = n; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    b = busy4;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_model(input string nm, input logic [7:0] v, input logic n);
    logic [27:0] e4, e2;
    bit o4, o2;
    e4 = model_seg(int'(v), n, 4, o4);
    e2 = model_seg(int'(v), n, 2, o2);
    chk({nm, " seg4"}, {4'd0, seg4}, {4'd0, e4});
    chk({nm, " ovf4"}, {31'd0, ovf4}, {31'd0, o4});
    chk({nm, " seg2"}, {18'd0, seg2}, {18'd0, e2[13:0]});
    chk({nm, " ovf2"}, {31'd0, ovf2}, {31'd0, o2});
  endtask

  initial begin
    int lat, e, cnt;
    logic b;
    logic [27:0] hold4;
    logic [7:0] rv;
    logic rn;

    tbl[0] = '{8'd0,   1'b0, {B, B, B, S0},  1'b0, {B, S0}, 1'b0};
    tbl[1] = '{8'd255, 1'b0, {B, S2, S5, S5}, 1'b0, {M, M},  1'b1};
    tbl[2] = '{8'd7,   1'b1, {B, B, M, S7},  1'b0, {M, S7}, 1'b0};
    tbl[3] = '{8'd250, 1'b1, {M, S2, S5, S0}, 1'b0, {M, M},  1'b1};
    tbl[4] = '{8'd100, 1'b0, {B, S1, S0, S0}, 1'b0, {M, M},  1'b1};
    tbl[5] = '{8'd99,  1'b0, {B, B, S9, S9}, 1'b0, {S9, S9}, 1'b0};
    tbl[6] = '{8'd0,   1'b1, {B, B, M, S0},  1'b0, {M, S0}, 1'b0};
    tbl[7] = '{8'd10,  1'b1, {B, M, S1, S0}, 1'b0, {M, M},  1'b1};
    tbl[8] = '{8'd9,   1'b1, {B, B, M, S9},  1'b0, {M, S9}, 1'b0};

    rst = 1'b1; load = 1'b0; neg = 1'b0; value = '0;
`ifdef SEG7_BLINK_EN
    blink = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset busy", {31'd0, busy4}, 32'd0);
    chk("reset done", {31'd0, done4}, 32'd0);
    chk("reset ovf2", {31'd0, ovf2}, 32'd0);
    chk("reset seg4", {4'd0, seg4}, {4'd0, 28'hFFFFFFF});
    chk("reset seg2", {18'd0, seg2}, {18'd0, 14'h3FFF});

    // Back-to-back: each load after the first lands in the cycle done is high.
    for (int i = 0; i < 9; i++) begin
      convert(tbl[i].v, tbl[i].n, lat, b);
      chk($sformatf("tbl%0d busy", i), {31'd0, b}, 32'd1);
      chk($sformatf("tbl%0d latency", i), lat, 32'd9);
      chk($sformatf("tbl%0d done2", i), {31'd0, done2}, 32'd1);
      chk($sformatf("tbl%0d busy off", i), {31'd0, busy4}, 32'd0);
      chk($sformatf("tbl%0d seg4", i), {4'd0, seg4}, {4'd0, tbl[i].s4});
      chk($sformatf("tbl%0d ovf4", i), {31'd0, ovf4}, {31'd0, tbl[i].o4});
      chk($sformatf("tbl%0d seg2", i), {18'd0, seg2}, {18'd0, tbl[i].s2});
      chk($sformatf("tbl%0d ovf2", i), {31'd0, ovf2}, {31'd0, tbl[i].o2});
    end

    @(posedge clk); #1;
    chk("done one cycle", {31'd0, done4}, 32'd0);

    convert(8'd100, 1'b0, lat, b);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf held", {31'd0, ovf2}, 32'd1);
    chk("seg held", {18'd0, seg2}, {18'd0, {M, M}});

    // Load pulse mid-conversion must be ignored.
    value = 8'd37; neg = 1'b0; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    e = 0;
    while (!done4 && e < 30) begin
      @(posedge clk); #1;
      e++;
      if (e == 2) begin value = 8'd99; load = 1'b1; end
      if (e == 3) load = 1'b0;
    end
    chk("busy-load latency", e, 32'd9);
    check_model("busy-load", 8'd37, 1'b0);
    cnt = 0;
    repeat (12) begin @(posedge clk); #1; if (done4) cnt++; end
    chk("busy-load extra done", cnt, 32'd0);

    // Reset during SHIFT aborts; start from an overflowed display.
    convert(8'd255, 1'b0, lat, b);
    value = 8'd200; load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst busy", {31'd0, busy4}, 32'd0);
    chk("midrst ovf2", {31'd0, ovf2}, 32'd0);
    chk("midrst seg4", {4'd0, seg4}, {4'd0, 28'hFFFFFFF});
    cnt = 0;
    repeat (15) begin @(posedge clk); #1; if (done4 || done2) cnt++; end
    chk("midrst no done", cnt, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rv = 8'($urandom_range(0, 255));
      rn = 1'($urandom_range(0, 1));
      convert(rv, rn, lat, b);
      chk($sformatf("rnd%0d latency", i), lat, 32'd9);
      check_model($sformatf("rnd%0d v=%0d n=%0d", i, rv, rn), rv, rn);
    end

`ifdef SEG7_BLINK_EN
    begin
      logic s_blank[24];
      convert(8'd7, 1'b0, lat, b);
      hold4 = seg4;
      blink = 1'b1;
      for (int j = 0; j < 24; j++) begin
        @(posedge clk); #1;
        s_blank[j] = (seg4 == 28'hFFFFFFF);
        if (!s_blank[j]) chk("blink pattern", {4'd0, seg4}, {4'd0, hold4});
      end
      for (int j = 4; j < 24; j++)
        chk($sformatf("blink period %0d", j), {31'd0, s_blank[j] ^ s_blank[j-4]}, 32'd1);
      blink = 1'b0;
      for (int j = 0; j < 10; j++) begin
        @(posedge clk); #1;
        chk("blink off steady", {4'd0, seg4}, {4'd0, hold4});
      end
    end
`else
    hold4 = seg4;
    repeat (10) @(posedge clk);
    #1 chk("steady seg", {4'd0, seg4}, {4'd0, hold4});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
